bus_resp_crossdomain: RTL and testbench

Read-side companion to the clkA→clkB toggle/ack bus crossing. A clkA-domain master issues a read request carrying an address. The request crosses to clkB, where the PMU-side register logic answers with data. The response data crosses back to clkA with a toggle handshake. A timeout protects clkA from a silent responder, and the toggles stay consistent afterwards.

---
 rtl/bus_cdc_pkg.sv | 5 +
 rtl/toggle_sync.sv | 15 +
 rtl/bus_resp_crossdomain.sv | 85 ++++++++
 tb/tb_bus_resp_crossdomain.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cdc_pkg.sv
// bus_cdc_pkg: shared types and constants for the clkA/clkB bus crossings
package bus_cdc_pkg;
  localparam int SYNC_STAGES = 3;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_a_t;
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: synchronises a toggle into clk and emits a one-cycle pulse per flip
module toggle_sync
  import bus_cdc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  output logic pulse_out
);
  logic [SYNC_STAGES-1:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], toggle_in};
  assign pulse_out = sync[SYNC_STAGES-1] ^ sync[SYNC_STAGES-2];
endmodule

// File: rtl/bus_resp_crossdomain.sv
// bus_resp_crossdomain: clkA read request crossing to clkB, response data returned by toggle handshake
module bus_resp_crossdomain
  import bus_cdc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clkA,
  input  logic              rstA,
  input  logic              clkB,
  input  logic              rstB,
  input  logic              ReqIn_clkA,
  input  logic [ADDR_W-1:0] AddrIn_clkA,
  output logic              Busy_clkA,
  output logic              RespValid_clkA,
  output logic [DATA_W-1:0] RespData_clkA,
  output logic              Timeout_clkA,
  output logic              ReqOut_clkB,
  output logic [ADDR_W-1:0] AddrOut_clkB,
  output logic              Pending_clkB,
  input  logic              RespIn_clkB,
  input  logic [DATA_W-1:0] RespDataIn_clkB
);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_a_t state, stateNext;
  logic reqToggle, respToggle, pendReg, respEdge, respTake;
  logic accept, deliver, expire, timeoutHit;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] respReg;
  logic [CNT_W-1:0] count;
  toggle_sync uSyncReq (.clk(clkB), .rst(rstB), .toggle_in(reqToggle), .pulse_out(ReqOut_clkB));
  toggle_sync uSyncResp (.clk(clkA), .rst(rstA), .toggle_in(respToggle), .pulse_out(respEdge));
  // TIMEOUT of 0 never matches, so the wait is unbounded
  assign timeoutHit = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));
  assign accept = (state == IDLE) && ReqIn_clkA;
  assign deliver = (state == WAIT) && respEdge;
  assign expire = (state == WAIT) && !respEdge && timeoutHit;
  assign Busy_clkA = state != IDLE;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = ReqIn_clkA ? WAIT : IDLE;
      WAIT:    stateNext = respEdge ? IDLE : timeoutHit ? DRAIN : WAIT;
      DRAIN:   stateNext = respEdge ? IDLE : DRAIN;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clkA or posedge rstA)
    if (rstA) begin
      state <= IDLE;
      reqToggle <= 1'b0;
      addrReg <= '0;
      count <= '0;
      RespValid_clkA <= 1'b0;
      RespData_clkA <= '0;
      Timeout_clkA <= 1'b0;
    end else begin
      state <= stateNext;
      RespValid_clkA <= deliver;
      Timeout_clkA <= expire;
      count <= accept ? '0 : (state == WAIT) ? count + 1'b1 : count;
      if (accept) begin
        addrReg <= AddrIn_clkA;
        reqToggle <= ~reqToggle;
      end
      if (deliver) RespData_clkA <= respReg;
    end
  // addrReg only moves in IDLE, so clkB can read it directly while a request is outstanding
  assign AddrOut_clkB = addrReg;
  assign Pending_clkB = ReqOut_clkB | pendReg;
  assign respTake = RespIn_clkB & Pending_clkB;
  always_ff @(posedge clkB or posedge rstB)
    if (rstB) begin
      pendReg <= 1'b0;
      respToggle <= 1'b0;
      respReg <= '0;
    end else begin
      pendReg <= Pending_clkB & ~respTake;
      if (respTake) begin
        respReg <= RespDataIn_clkB;
        respToggle <= ~respToggle;
      end
    end
endmodule

// File: tb/tb_bus_resp_crossdomain.sv
// tb_bus_resp_crossdomain: directed scenarios for the read-response clock crossing
`timescale 1ns/1ps
module tb_bus_resp_crossdomain;
  logic clkA = 0, clkB = 0, rstA = 1, rstB = 1;
  real halfB = 5.0;
  logic ReqIn_clkA = 0;
  logic [7:0] AddrIn_clkA = 0;
  logic Busy_clkA, RespValid_clkA, Timeout_clkA, ReqOut_clkB, Pending_clkB;
  logic [7:0] RespData_clkA, AddrOut_clkB;
  logic RespIn_clkB = 0;
  logic [7:0] RespDataIn_clkB = 0;
  int tests = 0, fails = 0, reqCnt = 0, validCnt = 0, timeoutCnt = 0;

  always #5 clkA = ~clkA;
  always #(halfB) clkB = ~clkB;

  bus_resp_crossdomain #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clkA(clkA), .rstA(rstA), .clkB(clkB), .rstB(rstB),
    .ReqIn_clkA(ReqIn_clkA), .AddrIn_clkA(AddrIn_clkA), .Busy_clkA(Busy_clkA),
    .RespValid_clkA(RespValid_clkA), .RespData_clkA(RespData_clkA), .Timeout_clkA(Timeout_clkA),
    .ReqOut_clkB(ReqOut_clkB), .AddrOut_clkB(AddrOut_clkB), .Pending_clkB(Pending_clkB),
    .RespIn_clkB(RespIn_clkB), .RespDataIn_clkB(RespDataIn_clkB)
  );

  always @(negedge clkB) if (ReqOut_clkB) reqCnt++;
  always @(negedge clkA) begin
    if (RespValid_clkA) validCnt++;
    if (Timeout_clkA) timeoutCnt++;
  end
  // the two domain resets are only supported as an overlapping pair
  always @(posedge clkA or posedge clkB)
    if (rstA !== rstB) begin
      fails++;
      $display("FAIL reset_overlap rstA=%b rstB=%b", rstA, rstB);
    end

  task automatic issue(input logic [7:0] a);
    @(negedge clkA);
    ReqIn_clkA = 1;
    AddrIn_clkA = a;
    @(posedge clkA);
    #1 ReqIn_clkA = 0;
  endtask

  task automatic respond(input int dly, input logic [7:0] d);
    repeat (dly) @(negedge clkB);
    RespDataIn_clkB = d;
    RespIn_clkB = 1;
    @(negedge clkB);
    RespIn_clkB = 0;
  endtask

  task automatic wait_req(output logic seen);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clkB);
      seen = ReqOut_clkB;
    end
  endtask

  task automatic wait_valid(output logic seen);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clkA);
      seen = RespValid_clkA;
    end
  endtask

  task automatic test_reset;
    @(negedge clkA);
    tests++; if (Busy_clkA !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", Busy_clkA); end
    tests++; if (RespValid_clkA !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", RespValid_clkA); end
    tests++; if (RespData_clkA !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", RespData_clkA); end
    tests++; if (Timeout_clkA !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", Timeout_clkA); end
    tests++; if (ReqOut_clkB !== 1'b0) begin fails++; $display("FAIL reset_reqout got=%b exp=0", ReqOut_clkB); end
    tests++; if (Pending_clkB !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", Pending_clkB); end
    tests++; if (AddrOut_clkB !== 8'h00) begin fails++; $display("FAIL reset_addrout got=%h exp=00", AddrOut_clkB); end
  endtask

  // equal, aligned clocks: ReqOut on the 3rd clkB edge, RespValid 4 clkA edges after RespIn
  task automatic test_basic;
    int v0;
    v0 = validCnt;
    issue(8'h3C);
    @(negedge clkB);
    tests++; if (Busy_clkA !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", Busy_clkA); end
    tests++; if (ReqOut_clkB !== 1'b0) begin fails++; $display("FAIL basic_reqout_early1 got=%b exp=0", ReqOut_clkB); end
    @(negedge clkB);
    tests++; if (ReqOut_clkB !== 1'b0) begin fails++; $display("FAIL basic_reqout_early2 got=%b exp=0", ReqOut_clkB); end
    @(negedge clkB);
    tests++; if (ReqOut_clkB !== 1'b1) begin fails++; $display("FAIL basic_reqout got=%b exp=1", ReqOut_clkB); end
    tests++; if (AddrOut_clkB !== 8'h3C) begin fails++; $display("FAIL basic_addrout got=%h exp=3c", AddrOut_clkB); end
    tests++; if (Pending_clkB !== 1'b1) begin fails++; $display("FAIL basic_pending got=%b exp=1", Pending_clkB); end
    @(negedge clkB);
    tests++; if (ReqOut_clkB !== 1'b0 || Pending_clkB !== 1'b1) begin fails++; $display("FAIL basic_pulse_len reqout=%b pending=%b exp=0/1", ReqOut_clkB, Pending_clkB); end
    respond(1, 8'hA5);
    tests++; if (Pending_clkB !== 1'b0) begin fails++; $display("FAIL basic_pending_clr got=%b exp=0", Pending_clkB); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clkA);
      tests++; if (RespValid_clkA !== (i == 3)) begin fails++; $display("FAIL basic_valid_edge%0d got=%b exp=%b", i, RespValid_clkA, i == 3); end
      if (i == 3) begin
        tests++; if (RespData_clkA !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", RespData_clkA); end
        tests++; if (Busy_clkA !== 1'b0) begin fails++; $display("FAIL basic_idle got=%b exp=0", Busy_clkA); end
      end
    end
    tests++; if (validCnt - v0 !== 1) begin fails++; $display("FAIL basic_valid_count got=%0d exp=1", validCnt - v0); end
  endtask

  task automatic test_back_to_back;
    int r0, v0;
    logic seen;
    r0 = reqCnt;
    v0 = validCnt;
    @(negedge clkA);
    ReqIn_clkA = 1;
    AddrIn_clkA = 8'h3C;
    wait_req(seen);
    tests++; if (!seen || AddrOut_clkB !== 8'h3C) begin fails++; $display("FAIL b2b_req1 seen=%b addr=%h exp=1/3c", seen, AddrOut_clkB); end
    respond(2, 8'hC3);
    wait_valid(seen);
    tests++; if (!seen || RespData_clkA !== 8'hC3) begin fails++; $display("FAIL b2b_data1 seen=%b data=%h exp=1/c3", seen, RespData_clkA); end
    tests++; if (reqCnt - r0 !== 1) begin fails++; $display("FAIL b2b_single_req got=%0d exp=1", reqCnt - r0); end
    AddrIn_clkA = 8'h3D;
    @(posedge clkA);
    #1 ReqIn_clkA = 0;
    tests++; if (Busy_clkA !== 1'b1) begin fails++; $display("FAIL b2b_reaccept got=%b exp=1", Busy_clkA); end
    wait_req(seen);
    tests++; if (!seen || AddrOut_clkB !== 8'h3D) begin fails++; $display("FAIL b2b_req2 seen=%b addr=%h exp=1/3d", seen, AddrOut_clkB); end
    respond(2, 8'hD3);
    wait_valid(seen);
    tests++; if (!seen || RespData_clkA !== 8'hD3) begin fails++; $display("FAIL b2b_data2 seen=%b data=%h exp=1/d3", seen, RespData_clkA); end
    repeat (12) @(negedge clkA);
    tests++; if (reqCnt - r0 !== 2 || validCnt - v0 !== 2) begin fails++; $display("FAIL b2b_counts req=%0d valid=%0d exp=2/2", reqCnt - r0, validCnt - v0); end
  endtask

  task automatic test_same_cycle;
    logic seen;
    issue(8'h77);
    wait_req(seen);
    tests++; if (!seen) begin fails++; $display("FAIL same_req seen=%b exp=1", seen); end
    respond(0, 8'h5A);
    tests++; if (Pending_clkB !== 1'b0) begin fails++; $display("FAIL same_pending got=%b exp=0", Pending_clkB); end
    wait_valid(seen);
    tests++; if (!seen || RespData_clkA !== 8'h5A) begin fails++; $display("FAIL same_data seen=%b data=%h exp=1/5a", seen, RespData_clkA); end
  endtask

  task automatic test_spurious;
    int v0;
    repeat (4) @(negedge clkA);
    v0 = validCnt;
    @(negedge clkB);
    tests++; if (Pending_clkB !== 1'b0) begin fails++; $display("FAIL spur_pending got=%b exp=0", Pending_clkB); end
    respond(0, 8'hFF);
    repeat (10) @(negedge clkA);
    tests++; if (validCnt !== v0) begin fails++; $display("FAIL spur_valid got=%0d exp=%0d", validCnt, v0); end
    tests++; if (RespData_clkA !== 8'h5A) begin fails++; $display("FAIL spur_data got=%h exp=5a", RespData_clkA); end
    tests++; if (Busy_clkA !== 1'b0) begin fails++; $display("FAIL spur_busy got=%b exp=0", Busy_clkA); end
  endtask

  task automatic test_timeout;
    int v0, t0, edges;
    logic seen;
    v0 = validCnt;
    t0 = timeoutCnt;
    issue(8'h40);
    edges = 0;
    seen = 0;
    while (edges < 40 && !seen) begin
      @(posedge clkA);
      #1 edges++;
      seen = Timeout_clkA;
    end
    tests++; if (!seen || edges !== 16) begin fails++; $display("FAIL to_edge seen=%b edges=%0d exp=1/16", seen, edges); end
    tests++; if (Busy_clkA !== 1'b1) begin fails++; $display("FAIL to_busy got=%b exp=1", Busy_clkA); end
    @(posedge clkA);
    #1;
    tests++; if (Timeout_clkA !== 1'b0 || Busy_clkA !== 1'b1) begin fails++; $display("FAIL to_drain timeout=%b busy=%b exp=0/1", Timeout_clkA, Busy_clkA); end
    repeat (5) @(negedge clkA);
    tests++; if (Busy_clkA !== 1'b1 || Pending_clkB !== 1'b1) begin fails++; $display("FAIL to_hold busy=%b pending=%b exp=1/1", Busy_clkA, Pending_clkB); end
    respond(1, 8'h11);
    repeat (10) @(negedge clkA);
    tests++; if (Busy_clkA !== 1'b0) begin fails++; $display("FAIL to_idle got=%b exp=0", Busy_clkA); end
    tests++; if (validCnt !== v0 || RespData_clkA !== 8'h5A) begin fails++; $display("FAIL to_late valid=%0d data=%h exp=%0d/5a", validCnt, RespData_clkA, v0); end
    tests++; if (timeoutCnt - t0 !== 1) begin fails++; $display("FAIL to_count got=%0d exp=1", timeoutCnt - t0); end
    issue(8'h22);
    wait_req(seen);
    tests++; if (!seen || AddrOut_clkB !== 8'h22) begin fails++; $display("FAIL to_next_req seen=%b addr=%h exp=1/22", seen, AddrOut_clkB); end
    respond(1, 8'h22);
    wait_valid(seen);
    tests++; if (!seen || RespData_clkA !== 8'h22) begin fails++; $display("FAIL to_next_data seen=%b data=%h exp=1/22", seen, RespData_clkA); end
  endtask

  task automatic test_reset_mid;
    int r0, v0;
    issue(8'h55);
    repeat (3) @(negedge clkA);
    rstA = 1;
    rstB = 1;
    #1;
    tests++; if (Busy_clkA !== 1'b0 || Pending_clkB !== 1'b0 || ReqOut_clkB !== 1'b0) begin fails++; $display("FAIL rst_ctrl busy=%b pending=%b reqout=%b exp=0/0/0", Busy_clkA, Pending_clkB, ReqOut_clkB); end
    tests++; if (RespData_clkA !== 8'h00 || AddrOut_clkB !== 8'h00) begin fails++; $display("FAIL rst_data data=%h addr=%h exp=00/00", RespData_clkA, AddrOut_clkB); end
    repeat (3) @(negedge clkA);
    rstA = 0;
    rstB = 0;
    r0 = reqCnt;
    v0 = validCnt;
    repeat (20) @(negedge clkA);
    tests++; if (reqCnt !== r0 || validCnt !== v0) begin fails++; $display("FAIL rst_no_pulse req=%0d valid=%0d exp=%0d/%0d", reqCnt, validCnt, r0, v0); end
    tests++; if (Busy_clkA !== 1'b0) begin fails++; $display("FAIL rst_idle got=%b exp=0", Busy_clkA); end
  endtask

  task automatic test_ratio_sweep;
    int r0, v0, t0, bad;
    logic seen;
    logic [7:0] a, d;
    for (int p = 0; p < 2; p++) begin
      halfB = (p == 0) ? 5.0 / 3.0 : 15.0;
      repeat (10) @(negedge clkA);
      r0 = reqCnt;
      v0 = validCnt;
      t0 = timeoutCnt;
      bad = 0;
      for (int n = 0; n < 50; n++) begin
        a = 8'($urandom);
        d = 8'($urandom);
        issue(a);
        wait_req(seen);
        tests++; if (!seen || AddrOut_clkB !== a) begin fails++; bad++; $display("FAIL sweep%0d_addr n=%0d seen=%b addr=%h exp=%h", p, n, seen, AddrOut_clkB, a); end
        respond((p == 0) ? int'($urandom_range(0, 3)) : 0, d);
        wait_valid(seen);
        tests++; if (!seen || RespData_clkA !== d) begin fails++; bad++; $display("FAIL sweep%0d_data n=%0d seen=%b data=%h exp=%h", p, n, seen, RespData_clkA, d); end
        if (bad > 6) break;
      end
      repeat (10) @(negedge clkA);
      tests++; if (reqCnt - r0 !== 50 || validCnt - v0 !== 50 || timeoutCnt !== t0) begin fails++; $display("FAIL sweep%0d_counts req=%0d valid=%0d timeouts=%0d exp=50/50/0", p, reqCnt - r0, validCnt - v0, timeoutCnt - t0); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clkA);
    rstA = 0;
    rstB = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_same_cycle;
    test_spurious;
    test_timeout;
    test_reset_mid;
    test_ratio_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
